// File: rtl/pio_pos_counter.sv
// -----------------------------------------------------------------------------
// pio_pos_counter
//   Avalon-MM position-feedback counter. Counts either the commanded
//   pulse/direction stream (from the PTO peripheral) or x4-decoded quadrature
//   encoder feedback into a signed 32-bit position, with compare match,
//   illegal-transition detection, index capture and an interrupt.
//
// Ports
//   clk, reset_n       system clock, asynchronous active-low reset
//   address[3:0]       register select
//                        0 CTRL     {irq_en, z_clr_en, invert, src, enable}
//                        1 POSITION live count (write loads)
//                        2 COMPARE
//                        3 STATUS   {last_dir, index_seen, quad_err, match}
//                        4 ERRCNT   saturating illegal-transition count
//   chipselect, write, read, writedata[31:0]
//                      slave strobes; write has priority over read
//   readdata[31:0]     registered; valid the cycle after chipselect&read,
//                      0 in every other cycle
//   enc_a, enc_b, enc_z  encoder channels (asynchronous)
//   pto_in, dir_in     commanded pulse train and direction (1 = positive)
//   irq                registered irq_en & (match | quad_err)
// -----------------------------------------------------------------------------
module pio_pos_counter #(
  parameter int FILTER_LEN = 4,   // 1..15 consecutive cycles to accept a level
  parameter int ERR_W      = 16   // illegal-transition counter width (<= 32)
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [3:0]  address,
  input  logic        chipselect,
  input  logic        write,
  input  logic        read,
  input  logic [31:0] writedata,
  output logic [31:0] readdata,
  input  logic        enc_a,
  input  logic        enc_b,
  input  logic        enc_z,
  input  logic        pto_in,
  input  logic        dir_in,
  output logic        irq
);

  localparam logic [3:0] ADDR_CTRL     = 4'd0;
  localparam logic [3:0] ADDR_POSITION = 4'd1;
  localparam logic [3:0] ADDR_COMPARE  = 4'd2;
  localparam logic [3:0] ADDR_STATUS   = 4'd3;
  localparam logic [3:0] ADDR_ERRCNT   = 4'd4;

  localparam int CNT_W = 4;

  // Channel positions inside the synchronizer / filter vectors.
  localparam int CH_A   = 0;
  localparam int CH_B   = 1;
  localparam int CH_Z   = 2;
  localparam int CH_PTO = 3;
  localparam int CH_DIR = 4;

  typedef enum logic [1:0] {
    STEP_NONE,
    STEP_UP,
    STEP_DOWN
  } step_t;

  // ---------------------------------------------------------------------------
  // Input synchronizers (all five channels)
  // ---------------------------------------------------------------------------
  logic [4:0] sync_meta;
  logic [4:0] sync_q;

  // NOTE: state is updated with non-blocking assignments so every flop samples
  // the pre-edge value of its neighbours, independent of statement order.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync_meta <= '0;
      sync_q    <= '0;
    end else begin
      sync_meta <= {dir_in, pto_in, enc_z, enc_b, enc_a};
      sync_q    <= sync_meta;
    end
  end

  // ---------------------------------------------------------------------------
  // Glitch filters for a, b, z, pto: the filtered level follows the
  // synchronized level only after FILTER_LEN consecutive differing cycles.
  // ---------------------------------------------------------------------------
  logic [3:0]       filt;
  logic [CNT_W-1:0] run_cnt [4];

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      filt <= '0;
      for (int i = 0; i < 4; i++) run_cnt[i] <= '0;
    end else begin
      for (int i = 0; i < 4; i++) begin
        if (sync_q[i] != filt[i]) begin
          if (run_cnt[i] == CNT_W'(FILTER_LEN - 1)) begin
            filt[i]    <= sync_q[i];
            run_cnt[i] <= '0;
          end else begin
            run_cnt[i] <= run_cnt[i] + CNT_W'(1);
          end
        end else begin
          run_cnt[i] <= '0;
        end
      end
    end
  end

  // Previous filtered levels track unconditionally so that enabling the
  // counter never sees a stale history.
  logic [1:0] prev_ab;
  logic       prev_z;
  logic       prev_pto;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      prev_ab  <= '0;
      prev_z   <= 1'b0;
      prev_pto <= 1'b0;
    end else begin
      prev_ab  <= {filt[CH_A], filt[CH_B]};
      prev_z   <= filt[CH_Z];
      prev_pto <= filt[CH_PTO];
    end
  end

  // ---------------------------------------------------------------------------
  // Registers
  // ---------------------------------------------------------------------------
  logic             ctrl_enable, ctrl_src, ctrl_invert, ctrl_z_clr_en, ctrl_irq_en;
  logic [31:0]      position;
  logic [31:0]      compare;
  logic             st_match, st_quad_err, st_index_seen, st_last_dir;
  logic [ERR_W-1:0] err_cnt;

  // ---------------------------------------------------------------------------
  // Step decode
  // ---------------------------------------------------------------------------
  logic [1:0] cur_ab;
  logic [1:0] cur_idx;
  logic [1:0] prev_idx;
  logic [1:0] quad_delta;
  logic       pto_rise;
  logic       z_rise;

  // Gray code 00,01,11,10 maps to phase 0,1,2,3; the phase difference mod 4
  // gives +1, -1, or 2 (both bits changed = illegal).
  assign cur_ab     = {filt[CH_A], filt[CH_B]};
  assign cur_idx    = {cur_ab[1], ^cur_ab};
  assign prev_idx   = {prev_ab[1], ^prev_ab};
  assign quad_delta = cur_idx - prev_idx;
  assign pto_rise   = filt[CH_PTO] & ~prev_pto;
  assign z_rise     = filt[CH_Z] & ~prev_z;

  logic wr_en, rd_en;
  logic wr_ctrl, wr_position, wr_compare, wr_status, wr_errcnt;

  assign wr_en       = chipselect & write;
  assign rd_en       = chipselect & read & ~write;
  assign wr_ctrl     = wr_en & (address == ADDR_CTRL);
  assign wr_position = wr_en & (address == ADDR_POSITION);
  assign wr_compare  = wr_en & (address == ADDR_COMPARE);
  assign wr_status   = wr_en & (address == ADDR_STATUS);
  assign wr_errcnt   = wr_en & (address == ADDR_ERRCNT);

  step_t       raw_step;
  step_t       step;
  logic        quad_illegal;
  logic        err_evt;
  logic        index_evt;
  logic        index_clr;
  logic        step_applied;
  logic [31:0] pos_nxt;
  logic [31:0] cmp_nxt;
  logic        match_set;

  // NOTE: every signal driven here gets a default first, so no path can
  // leave it unassigned and infer a latch.
  always_comb begin
    raw_step     = STEP_NONE;
    quad_illegal = 1'b0;
    step         = STEP_NONE;
    pos_nxt      = position;
    step_applied = 1'b0;

    if (ctrl_src) begin
      if (pto_rise) raw_step = sync_q[CH_DIR] ? STEP_UP : STEP_DOWN;
    end else begin
      case (quad_delta)
        2'd1:    raw_step = STEP_UP;
        2'd3:    raw_step = STEP_DOWN;
        2'd2:    quad_illegal = 1'b1;
        default: raw_step = STEP_NONE;
      endcase
    end

    if (ctrl_enable) begin
      case (raw_step)
        STEP_UP:   step = ctrl_invert ? STEP_DOWN : STEP_UP;
        STEP_DOWN: step = ctrl_invert ? STEP_UP : STEP_DOWN;
        default:   step = STEP_NONE;
      endcase
    end

    err_evt   = ctrl_enable & ~ctrl_src & quad_illegal;
    index_evt = ctrl_enable & ~ctrl_src & z_rise;
    index_clr = index_evt & ctrl_z_clr_en;

    // CPU write beats index clear, which beats the step.
    if (wr_position) begin
      pos_nxt = writedata;
    end else if (index_clr) begin
      pos_nxt = '0;
    end else if (step == STEP_UP) begin
      pos_nxt      = position + 32'd1;
      step_applied = 1'b1;
    end else if (step == STEP_DOWN) begin
      pos_nxt      = position - 32'd1;
      step_applied = 1'b1;
    end

    cmp_nxt   = wr_compare ? writedata : compare;
    // Edge of equality: only a transition from unequal to equal sets match.
    match_set = (pos_nxt == cmp_nxt) && (position != compare);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ctrl_enable   <= 1'b0;
      ctrl_src      <= 1'b0;
      ctrl_invert   <= 1'b0;
      ctrl_z_clr_en <= 1'b0;
      ctrl_irq_en   <= 1'b0;
      position      <= '0;
      compare       <= '0;
      st_match      <= 1'b0;
      st_quad_err   <= 1'b0;
      st_index_seen <= 1'b0;
      st_last_dir   <= 1'b0;
      err_cnt       <= '0;
      irq           <= 1'b0;
    end else begin
      if (wr_ctrl) begin
        ctrl_enable   <= writedata[0];
        ctrl_src      <= writedata[1];
        ctrl_invert   <= writedata[2];
        ctrl_z_clr_en <= writedata[3];
        ctrl_irq_en   <= writedata[4];
      end

      position <= pos_nxt;
      compare  <= cmp_nxt;

      // Sticky bits: a set in the same cycle as a W1C wins.
      st_match      <= match_set | (st_match      & ~(wr_status & writedata[0]));
      st_quad_err   <= err_evt   | (st_quad_err   & ~(wr_status & writedata[1]));
      st_index_seen <= index_evt | (st_index_seen & ~(wr_status & writedata[2]));

      if (step_applied) st_last_dir <= (step == STEP_UP);

      if (wr_errcnt) begin
        err_cnt <= '0;
      end else if (err_evt && (err_cnt != {ERR_W{1'b1}})) begin
        err_cnt <= err_cnt + ERR_W'(1);
      end

      irq <= ctrl_irq_en & (st_match | st_quad_err);
    end
  end

  // ---------------------------------------------------------------------------
  // Registered read port
  // ---------------------------------------------------------------------------
  logic [31:0] rd_mux;

  always_comb begin
    rd_mux = '0;
    case (address)
      ADDR_CTRL:     rd_mux = {27'd0, ctrl_irq_en, ctrl_z_clr_en, ctrl_invert,
                               ctrl_src, ctrl_enable};
      ADDR_POSITION: rd_mux = position;
      ADDR_COMPARE:  rd_mux = compare;
      ADDR_STATUS:   rd_mux = {28'd0, st_last_dir, st_index_seen, st_quad_err,
                               st_match};
      ADDR_ERRCNT:   rd_mux = 32'(err_cnt);
      default:       rd_mux = '0;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) readdata <= '0;
    else          readdata <= rd_en ? rd_mux : 32'd0;
  end

endmodule

// File: tb/tb_pio_pos_counter.sv
// -----------------------------------------------------------------------------
// tb_pio_pos_counter
//   Self-checking bench for pio_pos_counter. Stimulus updates a behavioural
//   model (position as an integer, sticky flags as bits); every register read
//   pushes the model's expected value into a queue that an independent
//   monitor pops when the registered read data appears.
// -----------------------------------------------------------------------------
module tb_pio_pos_counter;

  localparam int FILTER_LEN = 4;
  localparam int ERR_W      = 4;
  localparam int ERR_MAX    = (1 << ERR_W) - 1;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [3:0]  address;
  logic        chipselect;
  logic        write;
  logic        read;
  logic [31:0] writedata;
  logic [31:0] readdata;
  logic        enc_a, enc_b, enc_z, pto_in, dir_in;
  logic        irq;

  always #5 clk = ~clk;

  pio_pos_counter #(
    .FILTER_LEN (FILTER_LEN),
    .ERR_W      (ERR_W)
  ) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .address    (address),
    .chipselect (chipselect),
    .write      (write),
    .read       (read),
    .writedata  (writedata),
    .readdata   (readdata),
    .enc_a      (enc_a),
    .enc_b      (enc_b),
    .enc_z      (enc_z),
    .pto_in     (pto_in),
    .dir_in     (dir_in),
    .irq        (irq)
  );

  // ---------------------------------------------------------------------------
  // Counters and check
  // ---------------------------------------------------------------------------
  int compared   = 0;
  int mismatched = 0;

  task automatic check(input string name, input logic [31:0] actual,
                       input logic [31:0] expected);
    compared++;
    if (actual !== expected) begin
      mismatched++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, actual, expected);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Reference model
  // ---------------------------------------------------------------------------
  logic [31:0] m_pos, m_cmp;
  logic [4:0]  m_ctrl;
  bit          m_match, m_qerr, m_idx, m_ldir;
  int          m_err;
  int          phase;          // quadrature phase currently driven on a/b
  logic [1:0]  gray_seq [4] = '{2'b00, 2'b01, 2'b11, 2'b10};

  function automatic void m_reset();
    m_pos = '0; m_cmp = '0; m_ctrl = '0;
    m_match = 0; m_qerr = 0; m_idx = 0; m_ldir = 0; m_err = 0;
  endfunction

  function automatic void m_set_pos(input logic [31:0] v);
    if (v == m_cmp && m_pos != m_cmp) m_match = 1;
    m_pos = v;
  endfunction

  function automatic void m_set_cmp(input logic [31:0] v);
    if (m_pos == v && m_pos != m_cmp) m_match = 1;
    m_cmp = v;
  endfunction

  function automatic void m_step(input int dir);
    int d;
    d = m_ctrl[2] ? -dir : dir;
    m_set_pos(m_pos + 32'(d));
    m_ldir = (d > 0);
  endfunction

  function automatic logic [31:0] m_read(input logic [3:0] a);
    case (a)
      4'd0:    return {27'd0, m_ctrl};
      4'd1:    return m_pos;
      4'd2:    return m_cmp;
      4'd3:    return {28'd0, m_ldir, m_idx, m_qerr, m_match};
      4'd4:    return 32'(m_err);
      default: return 32'd0;
    endcase
  endfunction

  // ---------------------------------------------------------------------------
  // Scoreboard and monitor
  // ---------------------------------------------------------------------------
  logic [31:0] exp_q  [$];
  string       name_q [$];
  bit          probe = 0;      // direct probing in progress; monitor stands aside
  logic        rd_issued;

  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) rd_issued <= 1'b0;
    else          rd_issued <= chipselect & read & ~write;
  end

  initial begin
    logic [31:0] e;
    string       n;
    forever begin
      @(negedge clk);
      if (rd_issued && !probe) begin
        if (exp_q.size() == 0) begin
          compared++;
          mismatched++;
          $display("FAIL scoreboard: read data 0x%08h with no expectation", readdata);
        end else begin
          e = exp_q.pop_front();
          n = name_q.pop_front();
          check(n, readdata, e);
        end
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Bus and stimulus tasks
  // ---------------------------------------------------------------------------
  task automatic cpu_write(input logic [3:0] a, input logic [31:0] d);
    @(negedge clk);
    chipselect = 1'b1; write = 1'b1; address = a; writedata = d;
    case (a)
      4'd0: m_ctrl = d[4:0];
      4'd1: m_set_pos(d);
      4'd2: m_set_cmp(d);
      4'd3: begin
        if (d[0]) m_match = 0;
        if (d[1]) m_qerr  = 0;
        if (d[2]) m_idx   = 0;
      end
      4'd4: m_err = 0;
      default: ;
    endcase
    @(negedge clk);
    chipselect = 1'b0; write = 1'b0;
  endtask

  task automatic cpu_read(input logic [3:0] a, input string name);
    @(negedge clk);
    chipselect = 1'b1; read = 1'b1; address = a;
    exp_q.push_back(m_read(a));
    name_q.push_back(name);
    @(negedge clk);
    chipselect = 1'b0; read = 1'b0;
  endtask

  task automatic hold();
    repeat ($urandom_range(FILTER_LEN + 4, FILTER_LEN + 7)) @(negedge clk);
  endtask

  task automatic quad_move(input int dir);
    phase = (phase + 4 + dir) % 4;
    @(negedge clk);
    {enc_a, enc_b} = gray_seq[phase];
    if (m_ctrl[0] && !m_ctrl[1]) m_step(dir);
    hold();
  endtask

  task automatic quad_illegal();
    phase = (phase + 2) % 4;
    @(negedge clk);
    {enc_a, enc_b} = gray_seq[phase];
    if (m_ctrl[0] && !m_ctrl[1]) begin
      m_qerr = 1;
      if (m_err < ERR_MAX) m_err++;
    end
    hold();
  endtask

  task automatic pto_pulse(input logic d);
    @(negedge clk);
    dir_in = d;
    repeat (4) @(negedge clk);
    pto_in = 1'b1;
    if (m_ctrl[0] && m_ctrl[1]) m_step(d ? 1 : -1);
    hold();
    pto_in = 1'b0;
    hold();
  endtask

  // ---------------------------------------------------------------------------
  // Watchdog
  // ---------------------------------------------------------------------------
  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete, got timeout, expected finish");
    $fatal(1, "watchdog expired");
  end

  // ---------------------------------------------------------------------------
  // Main sequence
  // ---------------------------------------------------------------------------
  initial begin
    int edges;
    bit seen;

    reset_n = 1'b0;
    address = '0; chipselect = 1'b0; write = 1'b0; read = 1'b0; writedata = '0;
    enc_a = 1'b0; enc_b = 1'b0; enc_z = 1'b0; pto_in = 1'b0; dir_in = 1'b0;
    phase = 0;
    m_reset();
    repeat (3) @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);

    // ---- Reset state ----
    check("reset_irq", 32'(irq), 32'd0);
    check("idle_readdata", readdata, 32'd0);
    for (int a = 0; a < 5; a++) cpu_read(4'(a), $sformatf("reset_reg%0d", a));
    cpu_read(4'd7, "unmapped_read");
    @(negedge clk);
    check("idle_readdata_after_reads", readdata, 32'd0);

    // ---- PTO mode ----
    cpu_write(4'd0, 32'h3);
    dir_in = 1'b1;
    repeat (4) @(negedge clk);
    // Continuous read of POSITION to time the first count.
    probe = 1;
    chipselect = 1'b1; read = 1'b1; address = 4'd1;
    @(negedge clk);
    pto_in = 1'b1;
    m_step(1);
    edges = 0; seen = 0;
    while (edges < 40 && !seen) begin
      @(posedge clk);
      edges++;
      #1;
      if (readdata != 32'd0) seen = 1;
    end
    // POSITION moves FILTER_LEN+3 edges after the input edge; the registered
    // read data shows it one edge later.
    check("pto_first_count_latency", 32'(edges), 32'(FILTER_LEN + 4));
    @(negedge clk);
    chipselect = 1'b0; read = 1'b0;
    @(negedge clk);
    probe = 0;
    hold();
    pto_in = 1'b0;
    hold();
    for (int i = 0; i < 9; i++) pto_pulse(1'b1);
    cpu_read(4'd1, "pto_pos_after_10_up");
    for (int i = 0; i < 3; i++) pto_pulse(1'b0);
    cpu_read(4'd1, "pto_pos_after_3_down");
    cpu_read(4'd3, "pto_status_last_dir");
    repeat ($urandom_range(4, 10)) pto_pulse(1'($urandom_range(0, 1)));
    cpu_read(4'd1, "pto_pos_random");
    cpu_read(4'd3, "pto_status_random");

    // ---- Quadrature mode ----
    cpu_write(4'd1, 32'd0);
    cpu_write(4'd3, 32'hF);
    cpu_write(4'd0, 32'h1);
    for (int i = 0; i < 16; i++) quad_move(1);
    cpu_read(4'd1, "quad_fwd_4_cycles");
    for (int i = 0; i < 8; i++) quad_move(-1);
    cpu_read(4'd1, "quad_rev_2_cycles");
    cpu_write(4'd0, 32'h5);
    for (int i = 0; i < 4; i++) quad_move(1);
    cpu_read(4'd1, "quad_inverted_cycle");
    cpu_read(4'd3, "quad_inverted_last_dir");
    cpu_write(4'd0, 32'h0);
    quad_move(1);
    quad_move(1);
    cpu_read(4'd1, "quad_disabled_no_count");
    cpu_write(4'd0, 32'h1);
    hold();
    quad_move(1);
    cpu_read(4'd1, "quad_enable_no_spurious");
    repeat ($urandom_range(8, 20)) quad_move($urandom_range(0, 1) ? 1 : -1);
    cpu_read(4'd1, "quad_pos_random");
    cpu_read(4'd3, "quad_status_random");

    // ---- Illegal transitions, error counter, irq ----
    cpu_write(4'd3, 32'hF);
    cpu_write(4'd0, 32'h11);
    quad_illegal();
    cpu_read(4'd1, "illegal_pos_unchanged");
    cpu_read(4'd3, "illegal_status_quad_err");
    cpu_read(4'd4, "illegal_errcnt_1");
    check("irq_on_quad_err", 32'(irq), 32'(m_ctrl[4] & (m_match | m_qerr)));
    cpu_write(4'd3, 32'h2);
    check("irq_held_at_clear_edge", 32'(irq), 32'd1);
    @(negedge clk);
    check("irq_falls_after_clear", 32'(irq), 32'd0);
    cpu_write(4'd4, $urandom);
    cpu_read(4'd4, "errcnt_cleared_by_write");
    for (int i = 0; i < ERR_MAX + 2; i++) quad_illegal();
    cpu_read(4'd4, "errcnt_saturated");
    cpu_read(4'd3, "status_after_saturation");
    cpu_write(4'd3, 32'hF);
    cpu_write(4'd4, 32'd0);

    // ---- Wrap, compare match, glitch rejection ----
    cpu_write(4'd0, 32'h1);
    cpu_write(4'd1, 32'hFFFF_FFFE);
    cpu_write(4'd2, 32'h0000_0001);
    cpu_write(4'd3, 32'hF);
    for (int i = 0; i < 3; i++) quad_move(1);
    cpu_read(4'd1, "wrap_pos_1");
    cpu_read(4'd3, "wrap_match_set");
    @(negedge clk);
    enc_a = ~enc_a;
    @(negedge clk);
    enc_a = ~enc_a;
    hold();
    cpu_read(4'd1, "glitch_1cycle_ignored");
    @(negedge clk);
    enc_b = ~enc_b;
    repeat (FILTER_LEN - 1) @(negedge clk);
    enc_b = ~enc_b;
    hold();
    cpu_read(4'd1, "glitch_short_run_ignored");
    cpu_write(4'd3, 32'h1);
    hold();
    cpu_read(4'd3, "match_not_reset_while_equal");

    // ---- Index ----
    cpu_write(4'd0, 32'h9);
    cpu_write(4'd3, 32'hF);
    phase = (phase + 1) % 4;
    @(negedge clk);
    {enc_a, enc_b} = gray_seq[phase];
    enc_z = 1'b1;
    m_set_pos(32'd0);   // the coincident step is discarded
    m_idx = 1;
    hold();
    cpu_read(4'd1, "index_clears_pos");
    cpu_read(4'd3, "index_seen_set");
    enc_z = 1'b0;
    hold();
    cpu_write(4'd3, 32'h4);
    phase = (phase + 1) % 4;
    @(negedge clk);
    {enc_a, enc_b} = gray_seq[phase];
    enc_z = 1'b1;
    // Index clear and step land on edge FILTER_LEN+3; the write meets them there.
    repeat (FILTER_LEN + 2) @(negedge clk);
    chipselect = 1'b1; write = 1'b1; address = 4'd1; writedata = 32'h55;
    m_set_pos(32'h55);
    m_idx = 1;
    @(negedge clk);
    chipselect = 1'b0; write = 1'b0;
    hold();
    cpu_read(4'd1, "cpu_write_beats_index");
    cpu_read(4'd3, "index_seen_with_write");
    enc_z = 1'b0;
    hold();

    // ---- Asynchronous reset mid-operation ----
    cpu_write(4'd0, 32'h11);
    quad_illegal();
    check("irq_before_reset", 32'(irq), 32'd1);
    @(negedge clk);
    #2 reset_n = 1'b0;
    #1 check("irq_async_reset", 32'(irq), 32'd0);
    m_reset();
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    hold();
    cpu_read(4'd1, "post_reset_pos");
    cpu_read(4'd0, "post_reset_ctrl");
    cpu_read(4'd3, "post_reset_status");
    cpu_read(4'd4, "post_reset_errcnt");
    cpu_write(4'd0, 32'h1);
    hold();
    quad_move(1);
    cpu_read(4'd1, "post_reset_first_step");

    repeat (4) @(negedge clk);
    if (exp_q.size() != 0) begin
      compared++;
      mismatched++;
      $display("FAIL scoreboard_drain: got %0d pending, expected 0", exp_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/pio_pos_counter.md
Name: pio_pos_counter

Overview:
- Avalon-MM slave position-feedback block; consumes the pulse/direction stream driven to the servo drive, or the drive's quadrature encoder feedback.
- Keeps a signed 32-bit position count, compare match and error detection, so Nios can verify a pulse program or close the loop.
- Sits directly downstream of the PTO pulse-generator peripheral on the same bus.

Parameters:
FILTER_LEN, 4, consecutive clk cycles a synchronized input must hold a new value before the filtered version changes (range 1..15)
ERR_W, 16, width of the saturating illegal-transition counter

Ports:
clk  input  1  system clock
reset_n  input  1  asynchronous, active-low reset
address  input  4  register select
chipselect  input  1  slave select
write  input  1  write strobe
read  input  1  read strobe
writedata  input  32  write data
readdata  output  32  registered read data
enc_a  input  1  encoder channel A (asynchronous)
enc_b  input  1  encoder channel B (asynchronous)
enc_z  input  1  encoder index (asynchronous)
pto_in  input  1  commanded pulse train (PTO output)
dir_in  input  1  commanded motor direction; 1 = positive
irq  output  1  interrupt request, active high

Behaviour:
- Reset: all registers 0, readdata 0, irq 0, filter state and previous-AB state 0.
- Register map (address):
  - 0 CTRL RW: bit0 enable, bit1 src (0 = encoder, 1 = pto), bit2 invert, bit3 z_clr_en, bit4 irq_en.
  - 1 POSITION RW: read returns the live count; write loads it.
  - 2 COMPARE RW.
  - 3 STATUS: bit0 match, bit1 quad_err, bit2 index_seen are sticky and W1C; bit3 last_dir is RO.
  - 4 ERRCNT: read returns the zero-extended ERR_W count; any write clears it.
  - Other addresses: writes ignored, reads return 0.
- Bus timing:
  - Write takes effect on the clk edge where chipselect&write.
  - Read: readdata valid the cycle after chipselect&read.
  - readdata is 0 in any cycle without chipselect&read.
  - Write has priority over read.
- Input path:
  - Each of enc_a, enc_b, enc_z, pto_in, dir_in passes through a 2-flop synchronizer.
  - a, b, z and pto are then filtered: the output updates when the synchronized value differs from it for FILTER_LEN consecutive cycles; any bounce restarts the run count.
  - dir is synchronized only.
  - Latency from a clean input edge to a POSITION change: FILTER_LEN+3 clk edges.
- Quadrature decode (src = 0), x4, on filtered AB vs previous AB:
  - 00→01→11→10→00 = +1; reverse sequence = −1; no change = 0.
  - Both bits changed = illegal: no step, set quad_err, increment ERRCNT (saturates at all-ones).
- PTO decode (src = 1): rising edge of filtered pto: +1 if dir = 1, else −1. Falling edges are ignored.
- invert = 1 negates each step.
- last_dir updates on every counted step (1 = +).
- enable = 0:
  - No counting, no error counting.
  - Filters keep running and previous-AB keeps tracking, so asserting enable never produces a spurious step.
- Arithmetic: POSITION wraps modulo 2^32 (0x7FFFFFFF+1 → 0x80000000; 0−1 → 0xFFFFFFFF).
- Index: rising edge of filtered z with src = 0 and enable = 1 sets index_seen. If z_clr_en is also 1, POSITION ← 0 and that cycle's step is discarded.
- POSITION update priority, same cycle: CPU write > index clear > step.
- Compare:
  - match is set on the cycle POSITION becomes equal to COMPARE from unequal.
  - Edge detection, including equality caused by a CPU write to POSITION or COMPARE.
  - Holding equality does not re-set it after W1C.
- Sticky set and W1C in the same cycle: set wins.
- irq: registered, irq_en & (match | quad_err); deasserts one cycle after the causing bits are cleared.
- Reset asserted mid-operation: all state returns to reset values immediately (async); the first post-reset input level is absorbed into the filters without counting.

Test Plan:
- Reset, then read addr 0–4 → all 0; readdata 0 when idle; irq 0.
- src = 1, enable = 1, dir_in = 1, 10 pto pulses (each high/low ≥ FILTER_LEN+2 cycles), then dir_in = 0, 3 pulses → POSITION = 7, last_dir = 0; first change observed exactly FILTER_LEN+3 edges after the first pto edge.
- src = 0, four forward quadrature cycles → POSITION = 16. Two reverse cycles → 8. invert = 1 with one forward cycle → 4.
- Force AB 00→11 → POSITION unchanged, quad_err = 1, ERRCNT = 1. With irq_en = 1, irq rises. W1C bit1 → irq falls next cycle. Write ERRCNT → 0.
- POSITION = 0xFFFFFFFE, COMPARE = 0x00000001, three + steps → wraps to 1, match = 1. 1-cycle glitch on enc_a (FILTER_LEN = 4) → no count.
- z_clr_en = 1, filtered z rise coinciding with a step → POSITION = 0, index_seen = 1. CPU POSITION write of 0x55 in the same cycle → 0x55.
